// File: rtl/dsp_pkg.sv
// Shared DSP types and helpers for the fir/decimator chain.
// sample_t is the default-width sample; modules with a width parameter size their own ports.
package dsp_pkg;

    localparam int unsigned SAMPLE_BITS = 8;

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;

    // Counter width for n states. A one-state counter still gets one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with a combinational head view, giving one-cycle push-to-visible latency.
// Pointers carry an extra wrap bit so that full and empty can be told apart.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A push while full is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/decimator.sv
// Integer-factor downsampler: keeps one of every DecimationFactor valid samples
// and buffers the kept samples in a small FIFO behind a valid/ready output.
module decimator
    import dsp_pkg::*;
#(
    parameter int DataLengthBits   = 8,
    parameter int DecimationFactor = 4,
    parameter int DecimationPhase  = 0,
    parameter int FifoDepth        = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic signed [DataLengthBits-1:0] in,
    input  logic                             in_valid,
    output logic signed [DataLengthBits-1:0] out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             overflow,
    input  logic                             clear_overflow
);

    localparam int CntBits = clog2_min1(DecimationFactor);
    localparam logic [CntBits-1:0] PHASE_LAST = CntBits'(DecimationFactor - 1);
    localparam logic [CntBits-1:0] PHASE_KEEP = CntBits'(DecimationPhase);

    generate
        if (DecimationFactor < 1) begin : g_bad_factor
            $error("decimator: DecimationFactor must be at least 1");
        end
        if (DecimationPhase < 0 || DecimationPhase >= DecimationFactor) begin : g_bad_phase
            $error("decimator: DecimationPhase must lie in 0..DecimationFactor-1");
        end
        if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
            $error("decimator: FifoDepth must be a power of 2 and at least 2");
        end
    endgenerate

    logic [CntBits-1:0]              phase_reg;
    logic                            overflow_reg;
    logic                            keep;
    logic                            pop;
    logic                            push;
    logic                            drop;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [DataLengthBits-1:0]       fifo_head;

    // Invalid cycles do not count towards the decimation group.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_reg <= '0;
        end else if (in_valid) begin
            phase_reg <= (phase_reg == PHASE_LAST) ? '0 : phase_reg + CntBits'(1);
        end
    end

    assign keep = in_valid && (phase_reg == PHASE_KEEP);
    assign pop  = out_valid && out_ready;
    assign push = keep && (!fifo_full || pop);
    assign drop = keep && fifo_full && !pop;

    // A drop in the same cycle as a clear request leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (clear_overflow) begin
            overflow_reg <= 1'b0;
        end
    end

    sample_fifo #(
        .WIDTH (DataLengthBits),
        .DEPTH (FifoDepth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (in),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign out_valid = !fifo_empty;
    assign out       = fifo_head;
    assign overflow  = overflow_reg;

endmodule
